cbl_fetch_queue: RTL and testbench

//  Parametrised fetch front-end for the CaballoLoco pipelined core: owns the fetch PC and issues in-order

---
 rtl/cbl_fetch_queue.sv | 149 ++++++++++++++
 tb/tb_cbl_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbl_fetch_queue.sv
// Fetch front-end: owns the fetch PC, issues in-order instruction-memory requests under a
// credit limit, buffers returned words with their PC in a small FIFO and hands them to decode.
// A redirect flushes the FIFO and marks every in-flight response for discard.
module cbl_fetch_queue #(
    parameter int unsigned INSTR_WIDTH     = 32,
    parameter int unsigned NUM_INSTR       = 16,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned RESET_PC        = 0,
    localparam int unsigned PC_WIDTH       = $clog2(NUM_INSTR),
    localparam int unsigned CNT_WIDTH      = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_redirect,
    input  logic [PC_WIDTH-1:0]    i_redirect_pc,
    output logic                   o_mem_req,
    output logic [PC_WIDTH-1:0]    o_mem_addr,
    input  logic                   i_mem_ready,
    input  logic                   i_mem_valid,
    input  logic [INSTR_WIDTH-1:0] i_mem_data,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [PC_WIDTH-1:0]    o_pc,
    input  logic                   i_ready,
    output logic [CNT_WIDTH-1:0]   o_count,
    output logic                   o_err
);

    localparam int unsigned PTR_WIDTH = $clog2(QUEUE_DEPTH);
    localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]    resp_pc_q, resp_pc_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [OUT_WIDTH-1:0]   outstanding_q, outstanding_d;
    logic [OUT_WIDTH-1:0]   discard_q, discard_d;
    logic                   err_q, err_d;
    logic [INSTR_WIDTH-1:0] fifo_instr_q [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]    fifo_pc_q    [QUEUE_DEPTH];

    logic        mem_req;
    logic        accept;
    logic        resp;
    logic        push;
    logic        pop;
    logic [31:0] credit_used;

    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return (pc == PC_WIDTH'(NUM_INSTR - 1)) ? '0 : pc + PC_WIDTH'(1);
    endfunction

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_WIDTH'(QUEUE_DEPTH - 1)) ? '0 : ptr + PTR_WIDTH'(1);
    endfunction

    // Handshake decode and next-state for all control counters.
    always_comb begin
        credit_used = 32'(count_q) + 32'(outstanding_q);
        // Queued plus in-flight never exceeds depth, so responses never need backpressure.
        mem_req     = rst && !i_redirect && (credit_used < QUEUE_DEPTH)
                      && (32'(outstanding_q) < MAX_OUTSTANDING);
        accept      = mem_req && i_mem_ready;
        resp        = i_mem_valid && (outstanding_q != '0);
        push        = resp && (discard_q == '0) && !i_redirect;
        pop         = (count_q != '0) && i_ready && !i_redirect;

        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + OUT_WIDTH'(accept) - OUT_WIDTH'(resp);
        discard_d     = discard_q;
        err_d         = err_q || (i_mem_valid && (outstanding_q == '0));

        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc;
            resp_pc_d  = i_redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // Everything still in flight after this cycle belongs to the old path.
            discard_d  = outstanding_q - OUT_WIDTH'(resp);
        end else begin
            if (accept) fetch_pc_d = pc_inc(fetch_pc_q);
            if (push) begin
                resp_pc_d = pc_inc(resp_pc_q);
                wr_ptr_d  = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (resp && (discard_q != '0)) discard_d = discard_q - OUT_WIDTH'(1);
            count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= PC_WIDTH'(RESET_PC);
            resp_pc_q     <= PC_WIDTH'(RESET_PC);
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            err_q         <= err_d;
        end
    end

    // FIFO storage: word and its PC written together on push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= i_mem_data;
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
        end
    end

    // Outputs: head fields are zeroed when empty so stale entries never leak out.
    always_comb begin
        o_mem_req     = mem_req;
        o_mem_addr    = fetch_pc_q;
        o_valid       = (count_q != '0);
        o_instruction = o_valid ? fifo_instr_q[rd_ptr_q] : '0;
        o_pc          = o_valid ? fifo_pc_q[rd_ptr_q] : '0;
        o_count       = count_q;
        o_err         = err_q;
    end

    a_counters_bounded : assert property (@(posedge clk) disable iff (!rst)
        (outstanding_q <= OUT_WIDTH'(MAX_OUTSTANDING)) && (discard_q <= outstanding_q));

endmodule

// File: tb/tb_cbl_fetch_queue.sv
// Directed bench for cbl_fetch_queue with a latency-configurable in-order memory model.
module tb_cbl_fetch_queue;

    localparam int unsigned IW  = 32;
    localparam int unsigned NI  = 16;
    localparam int unsigned PCW = 4;
    localparam int unsigned CW  = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           i_redirect = 1'b0;
    logic [PCW-1:0] i_redirect_pc = '0;
    logic           o_mem_req;
    logic [PCW-1:0] o_mem_addr;
    logic           i_mem_ready = 1'b0;
    logic           i_mem_valid = 1'b0;
    logic [IW-1:0]  i_mem_data = '0;
    logic           o_valid;
    logic [IW-1:0]  o_instruction;
    logic [PCW-1:0] o_pc;
    logic           i_ready = 1'b0;
    logic [CW-1:0]  o_count;
    logic           o_err;

    cbl_fetch_queue #(
        .INSTR_WIDTH     (IW),
        .NUM_INSTR       (NI),
        .QUEUE_DEPTH     (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ready   (i_mem_ready),
        .i_mem_valid   (i_mem_valid),
        .i_mem_data    (i_mem_data),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .i_ready       (i_ready),
        .o_count       (o_count),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] word_of(input logic [PCW-1:0] a);
        return {16'hC0DE, 4'h0, a, 4'h5, ~a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: mem_lat is the number of clock edges from accept to response.
    typedef struct {
        logic [PCW-1:0] addr;
        int             due;
    } mem_req_t;

    mem_req_t       inflight[$];
    int             mem_lat   = 1;
    bit             chk_addr  = 1'b0;
    logic [PCW-1:0] exp_addr  = '0;
    int             addr_bad  = 0;
    int             n_acc     = 0;
    int             max_infl  = 0;
    int             spur_cnt  = 0;
    int             spur_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            inflight.delete();
            i_mem_valid = 1'b0;
            i_mem_data  = '0;
            exp_addr    = '0;
            addr_bad    = 0;
            n_acc       = 0;
            max_infl    = 0;
            spur_seen   = spur_cnt;
        end else begin
            i_mem_valid = 1'b0;
            i_mem_data  = '0;
            if (spur_cnt != spur_seen) begin
                i_mem_valid = 1'b1;
                spur_seen   = spur_cnt;
            end
            if (inflight.size() > 0 && inflight[0].due == cyc + 1) begin
                i_mem_valid = 1'b1;
                i_mem_data  = word_of(inflight[0].addr);
                void'(inflight.pop_front());
            end
            if (o_mem_req && i_mem_ready) begin
                if (chk_addr && o_mem_addr != exp_addr) addr_bad++;
                exp_addr = (exp_addr == PCW'(NI - 1)) ? '0 : exp_addr + 1'b1;
                inflight.push_back('{addr: o_mem_addr, due: cyc + 1 + mem_lat});
                n_acc++;
            end
            if (inflight.size() > max_infl) max_infl = inflight.size();
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int t = 0; t < 40 && !o_valid; t++) step();
        check_eq(tag, o_valid, 1);
    endtask

    task automatic wait_fill(input string tag);
        for (int t = 0; t < 40 && !(o_count == 2 && inflight.size() == 2); t++) step();
        check_eq(tag, {o_count, 8'(inflight.size())}, {3'd2, 8'd2});
    endtask

    initial begin
        int nv;
        int exp_disc;

        // Reset state, no clock edge yet.
        #2;
        check_eq("rst_mem_req", o_mem_req, 0);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_count", o_count, 0);
        check_eq("rst_pc", o_pc, 0);
        check_eq("rst_instr", o_instruction, 0);
        check_eq("rst_err", o_err, 0);

        // 1: latency 1, no stall, sequence wraps after 15, one word per cycle.
        mem_lat = 1; i_mem_ready = 1'b1; i_ready = 1'b1;
        do_reset();
        wait_valid("t1_first_valid");
        for (int i = 0; i < 17; i++) begin
            check_eq($sformatf("t1_valid_%0d", i), o_valid, 1);
            check_eq($sformatf("t1_pc_%0d", i), o_pc, 64'(i % 16));
            check_eq($sformatf("t1_instr_%0d", i), o_instruction, word_of(PCW'(i % 16)));
            step();
        end

        // 2: decode stalled; credit stops fetch at 4 words.
        i_ready = 1'b0;
        do_reset();
        repeat (12) step();
        check_eq("t2_count", o_count, 4);
        check_eq("t2_accepts", n_acc, 4);
        check_eq("t2_req_off", o_mem_req, 0);
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_pc_%0d", i), o_pc, 64'(i));
            check_eq($sformatf("t2_instr_%0d", i), o_instruction, word_of(PCW'(i)));
            step();
        end

        // 3: three-cycle memory (response two edges after accept, counting the request cycle).
        mem_lat = 2; chk_addr = 1'b1;
        do_reset();
        repeat (8) step();
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            if (o_valid) nv++;
            step();
        end
        check_eq("t3_words_per_12", nv, 8);
        repeat (10) step();
        check_eq("t3_max_outstanding", max_infl, 2);
        check_eq("t3_addr_errors", addr_bad, 0);
        chk_addr = 1'b0;

        // 4: redirect to 9 with 2 queued and 2 in flight.
        i_ready = 1'b0; mem_lat = 4;
        do_reset();
        wait_fill("t4_fill");
        i_redirect = 1'b1; i_redirect_pc = 4'd9;
        #1;
        check_eq("t4_no_req_redirect", o_mem_req, 0);
        step();
        i_redirect = 1'b0;
        check_eq("t4_valid_after", o_valid, 0);
        check_eq("t4_count_after", o_count, 0);
        i_ready = 1'b1;
        wait_valid("t4_valid_9");
        check_eq("t4_pc_9", o_pc, 9);
        check_eq("t4_instr_9", o_instruction, word_of(4'd9));
        step();
        wait_valid("t4_valid_10");
        check_eq("t4_pc_10", o_pc, 10);
        check_eq("t4_err", o_err, 0);

        // 5: redirect coinciding with a response and a pop.
        i_ready = 1'b0; mem_lat = 4;
        do_reset();
        wait_fill("t5_fill");
        for (int t = 0; t < 10 && !(inflight.size() > 0 && inflight[0].due == cyc + 1); t++)
            step();
        check_eq("t5_resp_due", (inflight.size() > 0 && inflight[0].due == cyc + 1), 1);
        exp_disc = inflight.size() - 1;
        i_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 4'd5;
        step();
        i_redirect = 1'b0;
        check_eq("t5_count", o_count, 0);
        check_eq("t5_valid", o_valid, 0);
        check_eq("t5_discard", dut.discard_q, 64'(exp_disc));
        wait_valid("t5_valid_5");
        check_eq("t5_pc_5", o_pc, 5);
        check_eq("t5_instr_5", o_instruction, word_of(4'd5));

        // 6: asynchronous reset mid-stream, restart, then a spurious response.
        mem_lat = 1; i_mem_ready = 1'b1; i_ready = 1'b1;
        do_reset();
        repeat (6) step();
        check_eq("t6_streaming", o_valid, 1);
        #3;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_valid", o_valid, 0);
        check_eq("t6_rst_count", o_count, 0);
        check_eq("t6_rst_pc", o_pc, 0);
        check_eq("t6_rst_instr", o_instruction, 0);
        check_eq("t6_rst_req", o_mem_req, 0);
        step();
        step();
        rst = 1'b1;
        wait_valid("t6_restart_valid");
        check_eq("t6_restart_pc", o_pc, 0);
        i_mem_ready = 1'b0;
        repeat (4) step();
        check_eq("t6_err_before", o_err, 0);
        spur_cnt++;
        step();
        step();
        check_eq("t6_err_set", o_err, 1);
        repeat (3) step();
        check_eq("t6_err_sticky", o_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, expected finish before 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
